i2c_codec_responder: RTL and testbench

- I2C target (slave) that receives the 3-byte audio-codec control writes issued by the team's I2C config sender/initializer: device address, then {reg_addr[6:0], data[8]}, then data[7:0].
- Oversamples SCL/SDA on i_clk, detects START/STOP, shifts bits, drives ACK open-drain, and emits a one-cycle register-write strobe per complete frame.
- Used as a loopback codec model in simulation/on-chip self-test, and as the bus-side front end of any register block we expose over I2C.

---
 rtl/i2c_codec_responder.sv | 197 +++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ==========================================================================
// i2c_codec_responder : I2C target accepting 3-byte codec register writes.
// Rev 1.0
// ==========================================================================
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'b0011010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_reg_valid,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_busy,
  output logic       o_abort
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_ACK_A  = 4'd2,
    S_BYTE1  = 4'd3,
    S_ACK_1  = 4'd4,
    S_BYTE2  = 4'd5,
    S_ACK_2  = 4'd6,
    S_EXTRA  = 4'd7,
    S_IGNORE = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_sda_oe;
  logic       r_valid;
  logic       r_abort;
  logic       r_busy;
  logic [6:0] r_reg_addr;
  logic [8:0] r_reg_data;
  logic [6:0] r_addr_pend;
  logic       r_data8_pend;
  logic [7:0] r_data_lo_pend;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_byte_done;
  logic w_addressed;
  logic w_shifting;

  // Idle bus is high on both lines, so the synchronizers reset to 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
      r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl       = r_scl_sync[SYNC_STAGES-1];
  assign w_sda       = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise  = w_scl & ~r_scl_hist;
  assign w_scl_fall  = ~w_scl & r_scl_hist;
  assign w_start     = r_sda_hist & ~w_sda & r_scl_hist & w_scl;
  assign w_stop      = ~r_sda_hist & w_sda & r_scl_hist & w_scl;
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  assign w_addressed = (r_state == S_ACK_A) || (r_state == S_BYTE1) ||
                       (r_state == S_ACK_1) || (r_state == S_BYTE2) ||
                       (r_state == S_ACK_2);
  assign w_shifting  = (r_state == S_ADDR) || (r_state == S_BYTE1) ||
                       (r_state == S_BYTE2) || (r_state == S_EXTRA);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_shift        <= 8'd0;
      r_bit_cnt      <= 4'd0;
      r_sda_oe       <= 1'b0;
      r_valid        <= 1'b0;
      r_abort        <= 1'b0;
      r_busy         <= 1'b0;
      r_reg_addr     <= 7'd0;
      r_reg_data     <= 9'd0;
      r_addr_pend    <= 7'd0;
      r_data8_pend   <= 1'b0;
      r_data_lo_pend <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      // Bus conditions win over any SCL edge seen in the same cycle.
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_abort   <= w_addressed;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
        r_abort   <= w_addressed;
        r_bit_cnt <= 4'd0;
      end else begin
        if (w_scl_rise && w_shifting) begin
          r_shift   <= {r_shift[6:0], w_sda};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        case (r_state)
          S_ADDR: begin
            if (w_byte_done) begin
              r_bit_cnt <= 4'd0;
              if (r_shift == {DEV_ADDR, 1'b0}) begin
                r_state  <= S_ACK_A;
                r_sda_oe <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_ACK_A: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_BYTE1;
            end
          end
          S_BYTE1: begin
            if (w_byte_done) begin
              r_bit_cnt    <= 4'd0;
              r_addr_pend  <= r_shift[7:1];
              r_data8_pend <= r_shift[0];
              r_sda_oe     <= 1'b1;
              r_state      <= S_ACK_1;
            end
          end
          S_ACK_1: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_BYTE2;
            end
          end
          S_BYTE2: begin
            if (w_byte_done) begin
              r_bit_cnt      <= 4'd0;
              r_data_lo_pend <= r_shift;
              r_sda_oe       <= 1'b1;
              r_state        <= S_ACK_2;
            end
          end
          S_ACK_2: begin
            if (w_scl_fall) begin
              r_sda_oe   <= 1'b0;
              r_valid    <= 1'b1;
              r_reg_addr <= r_addr_pend;
              r_reg_data <= {r_data8_pend, r_data_lo_pend};
              r_state    <= S_EXTRA;
            end
          end
          S_EXTRA: begin
            // Eight data clocks plus the NACK clock make up one extra byte.
            if (w_scl_fall && (r_bit_cnt == 4'd9)) begin
              r_bit_cnt <= 4'd0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_sda_oe    = r_sda_oe;
  assign o_reg_valid = r_valid;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_data  = r_reg_data;
  assign o_busy      = r_busy;
  assign o_abort     = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_responder.sv
`default_nettype none
// Directed and random I2C write frames checked against a frame-level model.
module tb_i2c_codec_responder;

  localparam logic [6:0] DEV = 7'b0011010;
  localparam int         Q   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       reg_valid;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic       abort_s;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_abort = 0;
  logic [6:0] last_addr = 7'd0;
  logic [8:0] last_data = 9'd0;
  bit in_frame = 1'b0;

  always #10 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_codec_responder #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (scl_m),
    .i_sda      (sda_bus),
    .o_sda_oe   (sda_oe),
    .o_reg_valid(reg_valid),
    .o_reg_addr (reg_addr),
    .o_reg_data (reg_data),
    .o_busy     (busy),
    .o_abort    (abort_s)
  );

  always @(negedge clk) begin
    if (reg_valid) begin
      n_valid++;
      last_addr = reg_addr;
      last_data = reg_data;
    end
    if (abort_s) n_abort++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    wait_q(); sda_m = b;
    wait_q(); scl_m = 1'b1;
    wait_q(); wait_q(); scl_m = 1'b0;
  endtask

  task automatic ack_clock(output logic acked);
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_m = 1'b1;
    wait_q();
    @(negedge clk) acked = ~sda_bus;
    wait_q(); scl_m = 1'b0;
  endtask

  // Handles both a fresh START on an idle bus and a repeated START mid-frame.
  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      wait_q(); sda_m = 1'b1;
      wait_q(); scl_m = 1'b1;
    end
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  // nfull complete bytes (with ack clock), then npart bits of the next byte,
  // then STOP or repeated START. Expectations come from frame-level rules.
  task automatic xfer(input logic [4:0][7:0] b, input int nfull, input int npart,
                      input bit end_stop, input string tag);
    int   v0, a0, exp_v, exp_a;
    bit   addressed;
    logic acked;
    v0 = n_valid;
    a0 = n_abort;
    addressed = (b[0] == {DEV, 1'b0});
    if (!in_frame) i2c_start();
    for (int i = 0; i < nfull; i++) begin
      for (int k = 7; k >= 0; k--) send_bit(b[i][k]);
      ack_clock(acked);
      check($sformatf("%s_ack%0d", tag, i), 32'(acked), 32'(addressed && i < 3));
    end
    for (int k = 0; k < npart; k++) send_bit(b[nfull][7-k]);
    if (end_stop) begin
      i2c_stop();
      in_frame = 1'b0;
    end else begin
      i2c_start();
      in_frame = 1'b1;
    end
    repeat (2*Q) @(posedge clk);
    exp_v = (addressed && nfull >= 3) ? 1 : 0;
    exp_a = (addressed && nfull >= 1 && nfull < 3) ? 1 : 0;
    @(negedge clk);
    check({tag, "_nvalid"}, 32'(n_valid - v0), 32'(exp_v));
    check({tag, "_nabort"}, 32'(n_abort - a0), 32'(exp_a));
    check({tag, "_busy"}, 32'(busy), 32'(!end_stop));
    if (exp_v == 1) begin
      check({tag, "_addr"}, 32'(last_addr), 32'(b[1][7:1]));
      check({tag, "_data"}, 32'(last_data), 32'({b[1][0], b[2]}));
    end
  endtask

  function automatic logic [4:0][7:0] frame(input logic [7:0] a0, input logic [7:0] a1,
                                             input logic [7:0] a2, input logic [7:0] a3);
    logic [4:0][7:0] f;
    f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3; f[4] = 8'hA5;
    return f;
  endfunction

  logic [6:0] init_addr [10] = '{7'h0F, 7'h00, 7'h01, 7'h02, 7'h04,
                                 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
  logic [8:0] init_data [10] = '{9'h000, 9'h097, 9'h097, 9'h079, 9'h015,
                                 9'h000, 9'h000, 9'h00A, 9'h000, 9'h001};

  initial begin
    logic [4:0][7:0] f;
    int v0, a0;
    logic [6:0] ra;
    logic [8:0] rd;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_valid", 32'(reg_valid), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_data", 32'(reg_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(abort_s), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    xfer(frame(8'h34, 8'h00, 8'h97, 8'h00), 3, 0, 1'b1, "basic");

    a0 = n_abort;
    for (int i = 0; i < 10; i++) begin
      ra = init_addr[i];
      rd = init_data[i];
      xfer(frame(8'h34, {ra, rd[8]}, rd[7:0], 8'h00), 3, 0, 1'b1, $sformatf("init%0d", i));
    end
    check("init_noabort", 32'(n_abort - a0), 32'd0);

    xfer(frame(8'h36, 8'h00, 8'h11, 8'h00), 3, 0, 1'b1, "wrongaddr");
    xfer(frame(8'h35, 8'h00, 8'h11, 8'h00), 3, 0, 1'b1, "readbit");
    xfer(frame(8'h34, 8'h0C, 8'h5A, 8'h00), 3, 0, 1'b1, "after_nack");

    xfer(frame(8'h34, 8'h12, 8'h00, 8'h00), 2, 0, 1'b1, "stop_b1");
    xfer(frame(8'h34, 8'h12, 8'hC3, 8'h00), 2, 3, 1'b0, "rstart_b2");
    xfer(frame(8'h34, 8'h0E, 8'h01, 8'h00), 3, 0, 1'b1, "after_rs");

    xfer(frame(8'h34, 8'h10, 8'h19, 8'hFF), 4, 0, 1'b1, "extra");

    // Reset while the target holds the ACK after the register-address byte.
    v0 = n_valid;
    a0 = n_abort;
    f = frame(8'h34, 8'h12, 8'h00, 8'h00);
    i2c_start();
    for (int i = 0; i < 2; i++) begin
      logic acked;
      for (int k = 7; k >= 0; k--) send_bit(f[i][k]);
      if (i == 0) ack_clock(acked);
    end
    wait_q();
    @(negedge clk);
    check("ack1_oe_before_rst", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_oe", 32'(sda_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    i2c_stop();
    in_frame = 1'b0;
    repeat (2*Q) @(posedge clk);
    @(negedge clk);
    check("rst_mid_nvalid", 32'(n_valid - v0), 32'd0);
    check("rst_mid_nabort", 32'(n_abort - a0), 32'd0);
    xfer(frame(8'h34, 8'h0A, 8'h06, 8'h00), 3, 0, 1'b1, "after_rst");

    for (int t = 0; t < 14; t++) begin
      f[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom);
      for (int j = 1; j < 5; j++) f[j] = 8'($urandom);
      xfer(f, $urandom_range(0, 4), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $sformatf("rnd%0d", t));
    end
    if (in_frame) begin
      i2c_stop();
      in_frame = 1'b0;
      repeat (2*Q) @(posedge clk);
    end
    @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("final_oe", 32'(sda_oe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
